// File: rtl/nf10_upb_pkg.sv
// Shared definitions for the NF10 user-packet-bus receive checker: stream and
// tuser field widths, error-flag bit positions, FSM state type and helpers.
package nf10_upb_pkg;

   localparam int TDATA_W     = 256;
   localparam int TKEEP_W     = 32;

   localparam int IN_PORT_W   = 3;
   localparam int IN_VPORT_W  = 3;
   localparam int OUT_PORT_W  = 8;
   localparam int OUT_VPORT_W = 8;
   localparam int PKT_LEN_W   = 14;

   // Error flag vector layout: {keep, tuser, len}
   localparam int ERR_W         = 3;
   localparam int ERR_LEN_BIT   = 0;
   localparam int ERR_TUSER_BIT = 1;
   localparam int ERR_KEEP_BIT  = 2;

   localparam logic [PKT_LEN_W-1:0] PKT_LEN_MAX = '1;

   typedef struct packed {
      logic [IN_PORT_W-1:0]   in_port;
      logic [IN_VPORT_W-1:0]  in_vport;
      logic [OUT_PORT_W-1:0]  out_port;
      logic [OUT_VPORT_W-1:0] out_vport;
      logic [PKT_LEN_W-1:0]   pkt_len;
   } tuser_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BODY = 1'b1
   } rx_state_t;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/nf10_upb_popcount32.sv
// Combinational byte-enable analysis: number of set bits in a 32-bit keep
// vector, and whether the set bits form one unbroken run starting at bit 0.
module nf10_upb_popcount32
   import nf10_upb_pkg::*;
(
   input  logic [TKEEP_W-1:0] i_keep,
   output logic [5:0]         o_count,
   output logic               o_contig
);

   // Count ones; any 0 directly below a 1 breaks the run from bit 0.
   always_comb begin
      o_count  = '0;
      o_contig = 1'b1;
      for (int i = 0; i < TKEEP_W; i++) begin
         o_count = o_count + {5'd0, i_keep[i]};
      end
      for (int i = 0; i < TKEEP_W - 1; i++) begin
         if (i_keep[i+1] && !i_keep[i]) begin
            o_contig = 1'b0;
         end
      end
   end

endmodule

// File: rtl/nf10_upb_axis_rx_checker.sv
// Receive-side checker for the NF10 user packet bus. Sinks an AXI-Stream,
// applies an optional periodic backpressure pattern, checks tuser stability,
// tkeep shape and declared length per packet, and keeps running statistics.
module nf10_upb_axis_rx_checker
   import nf10_upb_pkg::*;
#(
   parameter int STALL_PERIOD = 0,
   parameter int STALL_LEN    = 0
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [TDATA_W-1:0]     s_axis_tdata,
   input  logic [TKEEP_W-1:0]     s_axis_tkeep,
   input  logic                   s_axis_tvalid,
   input  logic                   s_axis_tlast,
   input  logic [IN_PORT_W-1:0]   s_axis_tuser_in_port,
   input  logic [IN_VPORT_W-1:0]  s_axis_tuser_in_vport,
   input  logic [OUT_PORT_W-1:0]  s_axis_tuser_out_port,
   input  logic [OUT_VPORT_W-1:0] s_axis_tuser_out_vport,
   input  logic [PKT_LEN_W-1:0]   s_axis_tuser_packet_length,
   output logic                   s_axis_tready,
   output logic [31:0]            pkt_count,
   output logic [47:0]            byte_count,
   output logic [15:0]            err_len_count,
   output logic [15:0]            err_tuser_count,
   output logic [15:0]            err_keep_count,
   output logic                   pkt_done,
   output logic [IN_PORT_W-1:0]   pkt_done_in_port,
   output logic [PKT_LEN_W-1:0]   pkt_done_len,
   output logic [ERR_W-1:0]       pkt_done_err
);

   // Counter wide enough to hold STALL_PERIOD itself, so the threshold never truncates.
   localparam int CNT_W = (STALL_PERIOD > 0) ? $clog2(STALL_PERIOD + 1) : 1;
   localparam int THR_I = (STALL_PERIOD > STALL_LEN) ? STALL_PERIOD - STALL_LEN : 0;
   localparam int LAST_I = (STALL_PERIOD > 0) ? STALL_PERIOD - 1 : 0;
   localparam logic [CNT_W-1:0] STALL_THR = CNT_W'(THR_I);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(LAST_I);

   rx_state_t              r_state, w_state_next;
   logic [CNT_W-1:0]       r_stall_cnt, w_stall_next;
   logic                   r_stall_run, r_tready, w_tready_next;
   tuser_t                 r_tuser, w_tuser_in, w_ref_tuser;
   logic [PKT_LEN_W-1:0]   r_len, w_len_base, w_len_new;
   logic [PKT_LEN_W:0]     w_len_sum;
   logic [ERR_W-1:0]       r_flags, w_flags_new;
   logic [5:0]             w_pop;
   logic                   w_contig;
   logic                   w_acc, w_first, w_tuser_mis, w_keep_bad, w_len_bad, w_len_sat;
   logic [31:0]            r_pkt_count;
   logic [47:0]            r_byte_count;
   logic [15:0]            r_err_len, r_err_tuser, r_err_keep;
   logic                   r_pkt_done;
   logic [IN_PORT_W-1:0]   r_done_in_port;
   logic [PKT_LEN_W-1:0]   r_done_len;
   logic [ERR_W-1:0]       r_done_err;
   logic                   w_unused_tdata;

   // Payload is carried but never inspected.
   assign w_unused_tdata = ^s_axis_tdata;

   nf10_upb_popcount32 u_popcount (
      .i_keep   (s_axis_tkeep),
      .o_count  (w_pop),
      .o_contig (w_contig)
   );

   assign w_acc   = s_axis_tvalid & r_tready;
   assign w_first = (r_state == ST_IDLE);

   assign w_tuser_in = '{in_port:   s_axis_tuser_in_port,
                         in_vport:  s_axis_tuser_in_vport,
                         out_port:  s_axis_tuser_out_port,
                         out_vport: s_axis_tuser_out_vport,
                         pkt_len:   s_axis_tuser_packet_length};

   // Stall phase for the next cycle; the first edge after reset enters phase 0.
   always_comb begin
      w_stall_next  = '0;
      w_tready_next = 1'b1;
      if (STALL_PERIOD > 0) begin
         if (r_stall_run && (r_stall_cnt != CNT_LAST)) begin
            w_stall_next = r_stall_cnt + CNT_W'(1);
         end
         w_tready_next = (w_stall_next < STALL_THR);
      end
   end

   // Stall counter and registered tready; tready is low throughout reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_stall_cnt <= '0;
         r_stall_run <= 1'b0;
         r_tready    <= 1'b0;
      end else begin
         r_stall_cnt <= w_stall_next;
         r_stall_run <= 1'b1;
         r_tready    <= w_tready_next;
      end
   end

   // Per-beat checks against the reference tuser (live on the first beat, latched after).
   always_comb begin
      w_ref_tuser = w_first ? w_tuser_in : r_tuser;
      w_len_base  = w_first ? '0 : r_len;
      w_tuser_mis = !w_first && (w_tuser_in != r_tuser);
      w_keep_bad  = s_axis_tlast ? !(w_contig && (|s_axis_tkeep))
                                 : (s_axis_tkeep != {TKEEP_W{1'b1}});
      w_len_sum   = {1'b0, w_len_base} + {{(PKT_LEN_W - 5){1'b0}}, w_pop};
      w_len_sat   = w_len_sum[PKT_LEN_W];
      w_len_new   = w_len_sat ? PKT_LEN_MAX : w_len_sum[PKT_LEN_W-1:0];
      w_len_bad   = w_len_sat ||
                    (s_axis_tlast && ((w_len_new != w_ref_tuser.pkt_len) ||
                                      (w_ref_tuser.pkt_len == '0)));
      w_flags_new = w_first ? '0 : r_flags;
      w_flags_new[ERR_LEN_BIT]   = w_flags_new[ERR_LEN_BIT]   | w_len_bad;
      w_flags_new[ERR_TUSER_BIT] = w_flags_new[ERR_TUSER_BIT] | w_tuser_mis;
      w_flags_new[ERR_KEEP_BIT]  = w_flags_new[ERR_KEEP_BIT]  | w_keep_bad;
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // FSM next state: a non-last accepted beat opens a packet, an accepted tlast closes it.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: if (w_acc && !s_axis_tlast) w_state_next = ST_BODY;
         ST_BODY: if (w_acc && s_axis_tlast)  w_state_next = ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Capture the reference tuser on the opening beat of each packet.
   always_ff @(posedge clk) begin
      if (w_acc && w_first) begin
         r_tuser <= w_tuser_in;
      end
   end

   // Packet accumulation, end-of-packet report and running statistics.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_len          <= '0;
         r_flags        <= '0;
         r_pkt_done     <= 1'b0;
         r_pkt_count    <= '0;
         r_byte_count   <= '0;
         r_err_len      <= '0;
         r_err_tuser    <= '0;
         r_err_keep     <= '0;
         r_done_in_port <= '0;
         r_done_len     <= '0;
         r_done_err     <= '0;
      end else begin
         r_pkt_done <= 1'b0;
         if (w_acc) begin
            if (s_axis_tlast) begin
               r_len          <= '0;
               r_flags        <= '0;
               r_pkt_done     <= 1'b1;
               r_pkt_count    <= r_pkt_count + 32'd1;
               r_byte_count   <= r_byte_count + {{(48 - PKT_LEN_W){1'b0}}, w_len_new};
               r_done_in_port <= w_ref_tuser.in_port;
               r_done_len     <= w_len_new;
               r_done_err     <= w_flags_new;
               if (w_flags_new[ERR_LEN_BIT])   r_err_len   <= sat_inc16(r_err_len);
               if (w_flags_new[ERR_TUSER_BIT]) r_err_tuser <= sat_inc16(r_err_tuser);
               if (w_flags_new[ERR_KEEP_BIT])  r_err_keep  <= sat_inc16(r_err_keep);
            end else begin
               r_len   <= w_len_new;
               r_flags <= w_flags_new;
            end
         end
      end
   end

   assign s_axis_tready    = r_tready;
   assign pkt_count        = r_pkt_count;
   assign byte_count       = r_byte_count;
   assign err_len_count    = r_err_len;
   assign err_tuser_count  = r_err_tuser;
   assign err_keep_count   = r_err_keep;
   assign pkt_done         = r_pkt_done;
   assign pkt_done_in_port = r_done_in_port;
   assign pkt_done_len     = r_done_len;
   assign pkt_done_err     = r_done_err;

endmodule

// File: tb/tb_nf10_upb_axis_rx_checker.sv
// Self-checking bench for nf10_upb_axis_rx_checker: directed vector table,
// randomized packets against a packet-level reference model, length
// saturation, backpressure pattern on a second instance, and mid-packet reset.
module tb_nf10_upb_axis_rx_checker;

   typedef struct packed {
      logic [2:0]  ip;
      logic [2:0]  iv;
      logic [7:0]  op;
      logic [7:0]  ov;
      logic [13:0] plen;
   } tu_t;

   typedef struct {
      logic [31:0] keep;
      tu_t         tu;
   } mbeat_t;

   typedef struct {
      logic [31:0] keep;
      logic        last;
      logic [2:0]  ip;
      logic [13:0] plen;
      logic        done;
      logic [13:0] dlen;
      logic [2:0]  dport;
      logic [2:0]  derr;
      logic [31:0] pkts;
      logic [47:0] bytes;
      logic [15:0] el, et, ek;
   } vec_t;

   localparam logic [31:0] FULL = 32'hFFFF_FFFF;

   logic         clk = 1'b0;
   logic         reset_n = 1'b1;
   logic [255:0] tdata = '0;
   logic [31:0]  tkeep = '0;
   logic         tvalid = 1'b0, tlast = 1'b0;
   logic [2:0]   ip = '0, iv = '0;
   logic [7:0]   op = '0, ov = '0;
   logic [13:0]  plen = '0;

   logic         m_tready, m_done;
   logic [31:0]  m_pkts;
   logic [47:0]  m_bytes;
   logic [15:0]  m_el, m_et, m_ek;
   logic [2:0]   m_dport, m_derr;
   logic [13:0]  m_dlen;

   // Stall instance: every beat is a full single-beat 32-byte packet.
   logic         s_valid = 1'b1, s_last = 1'b1;
   logic [31:0]  s_keep = FULL;
   logic [2:0]   s_ip = 3'd0;
   logic [7:0]   s_op = 8'd0;
   logic [13:0]  s_plen = 14'd32;
   logic         s_tready, s_done;
   logic [31:0]  s_pkts;
   logic [47:0]  s_bytes;
   logic [15:0]  s_el, s_et, s_ek;
   logic [2:0]   s_dport, s_derr;
   logic [13:0]  s_dlen;

   int n_cmp = 0;
   int n_err = 0;
   logic stall_done = 1'b0;

   // Reference model state
   mbeat_t      pq[$];
   logic        e_done;
   logic [31:0] e_pkts;
   logic [47:0] e_bytes;
   logic [15:0] e_el, e_et, e_ek;
   logic [13:0] e_dlen;
   logic [2:0]  e_dport, e_derr;

   always #5 clk = ~clk;

   nf10_upb_axis_rx_checker #(.STALL_PERIOD(0), .STALL_LEN(0)) dut (
      .clk(clk), .reset_n(reset_n), .s_axis_tdata(tdata), .s_axis_tkeep(tkeep),
      .s_axis_tvalid(tvalid), .s_axis_tlast(tlast),
      .s_axis_tuser_in_port(ip), .s_axis_tuser_in_vport(iv),
      .s_axis_tuser_out_port(op), .s_axis_tuser_out_vport(ov),
      .s_axis_tuser_packet_length(plen), .s_axis_tready(m_tready),
      .pkt_count(m_pkts), .byte_count(m_bytes), .err_len_count(m_el),
      .err_tuser_count(m_et), .err_keep_count(m_ek), .pkt_done(m_done),
      .pkt_done_in_port(m_dport), .pkt_done_len(m_dlen), .pkt_done_err(m_derr));

   nf10_upb_axis_rx_checker #(.STALL_PERIOD(16), .STALL_LEN(6)) dut_s (
      .clk(clk), .reset_n(reset_n), .s_axis_tdata(tdata), .s_axis_tkeep(s_keep),
      .s_axis_tvalid(s_valid), .s_axis_tlast(s_last),
      .s_axis_tuser_in_port(s_ip), .s_axis_tuser_in_vport(s_ip),
      .s_axis_tuser_out_port(s_op), .s_axis_tuser_out_vport(s_op),
      .s_axis_tuser_packet_length(s_plen), .s_axis_tready(s_tready),
      .pkt_count(s_pkts), .byte_count(s_bytes), .err_len_count(s_el),
      .err_tuser_count(s_et), .err_keep_count(s_ek), .pkt_done(s_done),
      .pkt_done_in_port(s_dport), .pkt_done_len(s_dlen), .pkt_done_err(s_derr));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic vec_t mkv(input logic [31:0] k, input logic l, input logic [2:0] p,
                                input logic [13:0] pl, input logic d, input logic [13:0] dl,
                                input logic [2:0] dp, input logic [2:0] de, input logic [31:0] pk,
                                input logic [47:0] by, input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] c);
      vec_t v;
      v.keep = k; v.last = l; v.ip = p; v.plen = pl; v.done = d; v.dlen = dl;
      v.dport = dp; v.derr = de; v.pkts = pk; v.bytes = by; v.el = a; v.et = b; v.ek = c;
      return v;
   endfunction

   task automatic model_clear();
      pq.delete();
      e_done = 0; e_pkts = '0; e_bytes = '0; e_el = '0; e_et = '0; e_ek = '0;
      e_dlen = '0; e_dport = '0; e_derr = '0;
   endtask

   // Evaluate a completed packet from its list of beats.
   task automatic model_packet();
      int raw = 0;
      int pc;
      int len;
      logic fl = 0, ft = 0, fk = 0;
      for (int i = 0; i < pq.size(); i++) begin
         pc = $countones(pq[i].keep);
         raw += pc;
         if (i > 0 && pq[i].tu != pq[0].tu) ft = 1;
         if (i < pq.size() - 1) begin
            if (pq[i].keep != FULL) fk = 1;
         end else if (pc == 0 || {1'b0, pq[i].keep} != ((33'd1 << pc) - 33'd1)) begin
            fk = 1;
         end
      end
      len = (raw > 16383) ? 16383 : raw;
      fl = (raw > 16383) || (len != int'(pq[0].tu.plen)) || (pq[0].tu.plen == 0);
      e_pkts  = e_pkts + 1;
      e_bytes = e_bytes + 48'(len);
      if (fl && e_el != 16'hFFFF) e_el++;
      if (ft && e_et != 16'hFFFF) e_et++;
      if (fk && e_ek != 16'hFFFF) e_ek++;
      e_dlen  = 14'(len);
      e_dport = pq[0].tu.ip;
      e_derr  = {fk, ft, fl};
      pq.delete();
   endtask

   // Present one cycle of stimulus (called #1 after a rising edge) and step the model.
   task automatic drive(input logic v, input logic [31:0] k, input logic l, input tu_t tu);
      logic acc;
      acc = v && m_tready;
      tvalid = v; tkeep = k; tlast = l;
      ip = tu.ip; iv = tu.iv; op = tu.op; ov = tu.ov; plen = tu.plen;
      tdata = {8{$urandom()}};
      @(posedge clk);
      #1;
      e_done = 0;
      if (acc) begin
         pq.push_back('{keep: k, tu: tu});
         if (l) begin
            model_packet();
            e_done = 1;
         end
      end
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".done"}, m_done, e_done);
      if (e_done) begin
         chk({tag, ".dlen"}, m_dlen, e_dlen);
         chk({tag, ".dport"}, m_dport, e_dport);
         chk({tag, ".derr"}, m_derr, e_derr);
         chk({tag, ".pkts"}, m_pkts, e_pkts);
         chk({tag, ".bytes"}, m_bytes, e_bytes);
         chk({tag, ".el"}, m_el, e_el);
         chk({tag, ".et"}, m_et, e_et);
         chk({tag, ".ek"}, m_ek, e_ek);
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, ".tready"}, m_tready, 0);
      chk({tag, ".pkts"}, m_pkts, 0);
      chk({tag, ".bytes"}, m_bytes, 0);
      chk({tag, ".errs"}, {m_el, m_et, m_ek}, 0);
      chk({tag, ".done"}, {m_done, m_dport, m_dlen, m_derr}, 0);
      chk({tag, ".s_tready"}, s_tready, 0);
      chk({tag, ".s_stats"}, {s_pkts, s_bytes[15:0]}, 0);
      chk({tag, ".s_rest"}, {s_el, s_et, s_ek, s_done, s_dport, s_dlen, s_derr}, 0);
   endtask

   // Backpressure pattern on the stall instance after the first reset release.
   initial begin
      logic [47:0] bc[48];
      @(posedge reset_n);
      for (int k = 0; k < 48; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("stall.tready.k%0d", k), s_tready, ((k % 16) < 10));
         bc[k] = s_bytes;
      end
      chk("stall.bytes.w0", bc[16] - bc[0], 48'd320);
      chk("stall.bytes.w1", bc[47] - bc[31], 48'd320);
      stall_done = 1'b1;
   end

   initial begin
      vec_t  vt[18];
      tu_t   tu;
      logic [31:0] keeps[5];
      int    nb, sum, waited;

      vt[0]  = mkv(FULL, 0, 0, 64, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
      vt[1]  = mkv(FULL, 1, 0, 64, 1, 64, 0, 3'b000, 1, 64, 0, 0, 0);
      vt[2]  = mkv(FULL, 0, 1, 96, 0, 64, 0, 3'b000, 1, 64, 0, 0, 0);
      vt[3]  = mkv(FULL, 0, 1, 96, 0, 64, 0, 3'b000, 1, 64, 0, 0, 0);
      vt[4]  = mkv(FULL, 1, 1, 96, 1, 96, 1, 3'b000, 2, 160, 0, 0, 0);
      vt[5]  = mkv(FULL, 0, 2, 42, 0, 96, 1, 3'b000, 2, 160, 0, 0, 0);
      vt[6]  = mkv(32'h3FF, 1, 2, 42, 1, 42, 2, 3'b000, 3, 202, 0, 0, 0);
      vt[7]  = mkv(FULL, 0, 0, 64, 0, 42, 2, 3'b000, 3, 202, 0, 0, 0);
      vt[8]  = mkv(FULL, 0, 0, 64, 0, 42, 2, 3'b000, 3, 202, 0, 0, 0);
      vt[9]  = mkv(FULL, 1, 0, 64, 1, 96, 0, 3'b001, 4, 298, 1, 0, 0);
      vt[10] = mkv(FULL, 0, 1, 96, 0, 96, 0, 3'b001, 4, 298, 1, 0, 0);
      vt[11] = mkv(FULL, 0, 3, 96, 0, 96, 0, 3'b001, 4, 298, 1, 0, 0);
      vt[12] = mkv(FULL, 1, 1, 96, 1, 96, 1, 3'b010, 5, 394, 1, 1, 0);
      vt[13] = mkv(32'h7FFFFFFF, 0, 0, 63, 0, 96, 1, 3'b010, 5, 394, 1, 1, 0);
      vt[14] = mkv(FULL, 1, 0, 63, 1, 63, 0, 3'b100, 6, 457, 1, 1, 1);
      vt[15] = mkv(32'h5, 1, 0, 2, 1, 2, 0, 3'b100, 7, 459, 1, 1, 2);
      vt[16] = mkv(32'h1, 1, 0, 0, 1, 1, 0, 3'b001, 8, 460, 2, 1, 2);
      vt[17] = mkv(32'h0, 1, 0, 0, 1, 0, 0, 3'b101, 9, 460, 3, 1, 3);

      // Power-on reset
      #1 reset_n = 1'b0;
      #1 check_zero("reset0");
      model_clear();
      repeat (2) @(posedge clk);
      #3 reset_n = 1'b1;
      @(posedge clk);
      #1;
      chk("tready_after_reset", m_tready, 1);

      // Directed vector table
      for (int i = 0; i < 18; i++) begin
         tu = '{ip: vt[i].ip, iv: 3'd0, op: 8'd0, ov: 8'd0, plen: vt[i].plen};
         drive(1'b1, vt[i].keep, vt[i].last, tu);
         chk($sformatf("vec%0d.done", i), m_done, vt[i].done);
         chk($sformatf("vec%0d.dlen", i), m_dlen, vt[i].dlen);
         chk($sformatf("vec%0d.dport", i), m_dport, vt[i].dport);
         chk($sformatf("vec%0d.derr", i), m_derr, vt[i].derr);
         chk($sformatf("vec%0d.pkts", i), m_pkts, vt[i].pkts);
         chk($sformatf("vec%0d.bytes", i), m_bytes, vt[i].bytes);
         chk($sformatf("vec%0d.el", i), m_el, vt[i].el);
         chk($sformatf("vec%0d.et", i), m_et, vt[i].et);
         chk($sformatf("vec%0d.ek", i), m_ek, vt[i].ek);
      end

      // Randomized packets against the reference model
      for (int p = 0; p < 40; p++) begin
         nb = $urandom_range(1, 5);
         sum = 0;
         for (int b = 0; b < nb; b++) begin
            if (b < nb - 1) begin
               keeps[b] = ($urandom_range(0, 9) == 0) ? $urandom() : FULL;
            end else if ($urandom_range(0, 9) == 0) begin
               keeps[b] = $urandom();
            end else begin
               int n = $urandom_range(1, 32);
               keeps[b] = (n == 32) ? FULL : ((32'd1 << n) - 32'd1);
            end
            sum += $countones(keeps[b]);
         end
         tu = tu_t'({$urandom(), 4'($urandom())});
         tu.plen = ($urandom_range(0, 4) != 0) ? 14'(sum) : 14'($urandom_range(0, 200));
         for (int b = 0; b < nb; b++) begin
            if ($urandom_range(0, 3) == 0) begin
               drive(1'b0, '0, 1'b0, tu);
               check_model($sformatf("rnd%0d.idle", p));
            end
            if (b > 0 && $urandom_range(0, 9) == 0) tu.ip = tu.ip + 3'd1;
            drive(1'b1, keeps[b], (b == nb - 1), tu);
            check_model($sformatf("rnd%0d.b%0d", p, b));
         end
      end

      // Length accumulator saturation: 513 full beats exceed 16383 bytes
      tu = '{ip: 3'd5, iv: 3'd1, op: 8'd2, ov: 8'd3, plen: 14'd16383};
      for (int b = 0; b < 513; b++) begin
         drive(1'b1, FULL, (b == 512), tu);
         if (b >= 510) check_model($sformatf("sat.b%0d", b));
      end
      chk("sat.dlen", m_dlen, 14'd16383);
      chk("sat.derr", m_derr, 3'b001);

      // Let the backpressure checker finish, bounded
      waited = 0;
      while (!stall_done && waited < 200) begin
         @(posedge clk);
         waited++;
      end
      #1;
      chk("stall.finished", stall_done, 1);

      // Reset in the middle of the second beat of a 7-beat 224-byte packet
      tu = '{ip: 3'd4, iv: 3'd0, op: 8'd0, ov: 8'd0, plen: 14'd224};
      drive(1'b1, FULL, 1'b0, tu);
      tvalid = 1'b1;
      #2 reset_n = 1'b0;
      #1 check_zero("rst_mid.now");
      @(posedge clk);
      @(posedge clk);
      #1 check_zero("rst_mid.held");
      #2;
      tvalid = 1'b0;
      reset_n = 1'b1;
      model_clear();
      @(posedge clk);
      #1;
      tu = '{ip: 3'd1, iv: 3'd2, op: 8'd3, ov: 8'd4, plen: 14'd64};
      drive(1'b1, FULL, 1'b0, tu);
      check_model("post_rst.b0");
      drive(1'b1, FULL, 1'b1, tu);
      check_model("post_rst.b1");
      chk("post_rst.pkts", m_pkts, 32'd1);
      chk("post_rst.bytes", m_bytes, 48'd64);
      chk("post_rst.errs", {m_el, m_et, m_ek}, 0);
      drive(1'b0, '0, 1'b0, tu);
      chk("post_rst.done_pulse", m_done, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/nf10_upb_axis_rx_checker.md
NF10_UPB_AXIS_RX_CHECKER -- requirements
Module: nf10_upb_axis_rx_checker

Interface
REQ-001 Parameter STALL_PERIOD, default 0, backpressure period in clocks (0 = tready never deasserted by pattern).
REQ-002 Parameter STALL_LEN, default 0, clocks per period with tready low (STALL_LEN < STALL_PERIOD).
REQ-003 clk  in  1  sole clock.
REQ-004 reset_n  in  1  reset, asynchronous, active-low.
REQ-005 s_axis_tdata  in  256  stream data (not checked).
REQ-006 s_axis_tkeep  in  32  byte enables, bit0 = byte0.
REQ-007 s_axis_tvalid / s_axis_tlast  in  1 each  AXI-Stream handshake and end of packet.
REQ-008 s_axis_tuser_in_port, s_axis_tuser_in_vport  in  3 each; s_axis_tuser_out_port, s_axis_tuser_out_vport  in  8 each; s_axis_tuser_packet_length  in  14  declared bytes.
REQ-009 s_axis_tready  out  1  backpressure to the upstream switch output.
REQ-010 pkt_count  out  32  accepted packets.
REQ-011 byte_count  out  48  accepted bytes (tkeep popcount sum).
REQ-012 err_len_count, err_tuser_count, err_keep_count  out  16 each  error counters.
REQ-013 pkt_done  out  1  one-cycle pulse after each accepted tlast beat.
REQ-014 pkt_done_in_port  out  3 and pkt_done_len  out  14: in_port and counted length of the last packet; pkt_done_err  out  3: {keep,tuser,len} flags of that packet.

Function
REQ-015 A beat is accepted iff s_axis_tvalid and s_axis_tready are both high at the rising clk edge; no other beat has any effect.
REQ-016 FSM states: IDLE (awaiting first beat) and BODY (mid-packet); IDLE->BODY on an accepted non-last beat; BODY->IDLE on an accepted tlast beat; an accepted tlast beat in IDLE (single-beat packet) stays in IDLE.
REQ-017 The first beat latches all five tuser fields. In BODY, any accepted beat whose tuser differs from the latched value sets the packet's tuser flag.
REQ-018 Non-last beats require tkeep = 32'hFFFFFFFF. Last beats require contiguous ones from bit0 and at least one set bit. A violation sets the keep flag.
REQ-019 Per-packet length accumulator: 14 bits, adds popcount(tkeep) per beat, saturates at 16383 (saturation forces the len flag).
REQ-020 On tlast, the len flag is set if accumulated length differs from the latched packet_length; packet_length 0 always sets it.
REQ-021 One clock after the tlast beat: pkt_done = 1; pkt_count +1; byte_count += length; each error counter with its flag set +1; pkt_done_* updated; flags cleared for the next packet.
REQ-022 Error counters saturate at 16'hFFFF. pkt_count and byte_count wrap modulo 2^32 / 2^48.
REQ-023 Stall counter runs freely 0..STALL_PERIOD-1 and wraps. s_axis_tready = 0 when counter >= STALL_PERIOD-STALL_LEN, else 1. If STALL_PERIOD = 0, tready stays 1 (after reset).
REQ-024 s_axis_tready is a registered output with no combinational dependence on tvalid.
REQ-025 The stall pattern applies in both IDLE and BODY, independent of packet boundaries.

Reset
REQ-026 Asserting reset_n low immediately forces:
- FSM to IDLE
- s_axis_tready = 0
- all counters, accumulator, flags and pkt_done_* to 0
- pkt_done = 0
REQ-027 After reset_n rises, tready follows REQ-023 from stall counter 0 at the first clk edge. A packet cut by reset is discarded and not counted.

Structure
REQ-028 The shared package nf10_upb_pkg holds:
- the tuser field widths (3/3/8/8/14)
- TDATA_W = 256, TKEEP_W = 32
- the error-flag bit positions
REQ-029 One sub-module, nf10_upb_popcount32: combinational 32-bit popcount to 6 bits, plus a contiguity flag.

Verification
REQ-030 Two packets are sent: 2 beats with full keep and packet_length 64, then 3 beats with full keep and packet_length 96, with STALL_PERIOD = 0. Required: pkt_count 2, byte_count 160, all error counters 0, two pkt_done pulses.
REQ-031 Two beats are sent: full keep, then keep 32'h000003FF with tlast, packet_length 42, in_port 2. Required: pkt_done_len 42, pkt_done_in_port 2, pkt_done_err 3'b000.
REQ-032 Three full beats are sent with packet_length 64. Required: err_len_count 1, pkt_done_len 96, pkt_done_err 3'b001.
REQ-033 in_port changes 1->3 on the second of three beats. Required: err_tuser_count 1. A non-last beat with keep 32'h7FFFFFFF is also sent. Required: err_keep_count 1.
REQ-034 STALL_PERIOD = 16, STALL_LEN = 6, tvalid held high continuously. Required: tready low exactly in counter phases 10-15 of every period, and byte_count increases by 32 × 10 per 16 clocks.
REQ-035 reset_n is pulsed low during the second beat of a 7-beat 224-byte packet, and a clean 64-byte packet is sent afterward. Required: all outputs 0 during reset, then pkt_count 1, byte_count 64, no errors.
